// File: rtl/tim_apb_pkg.sv
// Shared definitions for the timer APB initiator: FSM state codes, timer register map
// and the response payload used by the master and its bench.
package tim_apb_pkg;

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Timer register slave map (byte addresses)
  localparam logic [APB_ADDR_W-1:0] TCR_ADDR   = 12'h000;
  localparam logic [APB_ADDR_W-1:0] TDR0_ADDR  = 12'h004;
  localparam logic [APB_ADDR_W-1:0] TDR1_ADDR  = 12'h008;
  localparam logic [APB_ADDR_W-1:0] TCMP0_ADDR = 12'h00C;
  localparam logic [APB_ADDR_W-1:0] TCMP1_ADDR = 12'h010;
  localparam logic [APB_ADDR_W-1:0] TIER_ADDR  = 12'h014;
  localparam logic [APB_ADDR_W-1:0] TISR_ADDR  = 12'h018;
  localparam logic [APB_ADDR_W-1:0] THCSR_ADDR = 12'h01C;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } tim_rsp_t;

endpackage

// File: rtl/tim_apb_master_if.sv
// APB bus between the timer APB initiator (master) and the timer register slave.
interface tim_apb_master_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/tim_apb_wdog.sv
// ACCESS-phase watchdog for the timer APB initiator; compiled only when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module tim_apb_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);
  localparam int unsigned CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fires on the stalled cycle that would bring the count to TIMEOUT_CYCLES
  assign expire_c = inc && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/tim_apb_master.sv
// APB initiator for the timer register slave: single-beat command in, SETUP/ACCESS, response out.
// Define APB_TIMEOUT_EN to abort ACCESS phases stalled for TIMEOUT_CYCLES cycles.
module tim_apb_master
  import tim_apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  tim_apb_master_if.master      apb
);
  localparam int unsigned STRB_W = DATA_W / 8;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("tim_apb_master: TIMEOUT_CYCLES must be nonzero");
  end

  logic [1:0]        state_q, state_d;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic              accept_c, misaligned_c, done_c, timeout_c;

  assign cmd_ready    = (state_q == ST_IDLE);
  assign accept_c     = cmd_valid && cmd_ready;
  assign misaligned_c = (cmd_addr[1:0] != 2'b00);
  assign done_c       = (state_q == ST_ACCESS) && apb.pready;

`ifdef APB_TIMEOUT_EN
  tim_apb_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (state_q == ST_SETUP),
    .inc       ((state_q == ST_ACCESS) && !apb.pready),
    .expire_c  (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = misaligned_c ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (apb.pready || timeout_c) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, registered bus/response outputs and command capture
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q <= (state_d == ST_ACCESS);
      rsp_valid <= (state_d == ST_RESP);
      busy      <= (state_d != ST_IDLE);
      if (accept_c) begin
        paddr_q     <= cmd_addr;
        pwrite_q    <= cmd_write;
        pwdata_q    <= cmd_write ? cmd_wdata : '0;
        pstrb_q     <= cmd_write ? cmd_strb  : '0;
        rsp_rdata   <= '0;
        rsp_err     <= misaligned_c;
        rsp_timeout <= 1'b0;
      end
      if (done_c) begin
        rsp_rdata <= (pwrite_q || apb.pslverr) ? '0 : apb.prdata;
        rsp_err   <= apb.pslverr;
      end else if (timeout_c) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
endmodule

// File: tb/tb_tim_apb_master.sv
// Bench for tim_apb_master: directed timer-register scenarios plus randomized transfers
// checked against a transaction-level response/latency model.
module tb_tim_apb_master;
  import tim_apb_pkg::*;

  localparam int unsigned TMO = 4;

  logic        sys_clk, sys_rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  tim_apb_master_if #(.ADDR_W(12), .DATA_W(32)) apb ();

  tim_apb_master #(
    .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .apb(apb.master)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: what the initiator must return and how long it takes
  task automatic run_txn(input string name, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, input int waits,
                         input logic [31:0] rd, input logic serr, input int hold);
    tim_rsp_t exp_rsp;
    logic     mis, tmo;
    int       acc, exp_lat, exp_sel, sel_cnt, acc_cnt, lat;
    bit       done;
    mis = (addr[1:0] != 2'b00);
`ifdef APB_TIMEOUT_EN
    tmo = !mis && (waits >= int'(TMO));
`else
    tmo = 1'b0;
`endif
    acc             = tmo ? int'(TMO) : waits + 1;
    exp_lat         = mis ? 1 : 2 + acc;
    exp_sel         = mis ? 0 : 1 + acc;
    exp_rsp.timeout = tmo;
    exp_rsp.err     = mis || tmo || serr;
    exp_rsp.rdata   = (mis || tmo || serr || wr) ? 32'h0 : rd;

    chk({name, ".cmd_ready"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 12'($urandom);
    cmd_wdata = $urandom; cmd_strb = 4'($urandom);

    sel_cnt = 0; acc_cnt = 0; lat = 0; done = 0;
    for (int n = 1; n <= 64 && !done; n++) begin
      if (rsp_valid) begin
        lat = n; done = 1;
      end else begin
        if (apb.psel) begin
          sel_cnt++;
          chk({name, ".paddr"},  64'(apb.paddr),  64'(addr));
          chk({name, ".pwrite"}, 64'(apb.pwrite), 64'(wr));
          chk({name, ".pwdata"}, 64'(apb.pwdata), wr ? 64'(wd) : 64'(0));
          chk({name, ".pstrb"},  64'(apb.pstrb),  wr ? 64'(st) : 64'(0));
        end
        if (apb.psel && apb.penable) begin
          acc_cnt++;
          if (acc_cnt == waits + 1) begin
            apb.pready = 1'b1; apb.prdata = rd; apb.pslverr = serr;
          end else begin
            apb.pready = 1'b0; apb.prdata = $urandom; apb.pslverr = 1'($urandom);
          end
        end else begin
          apb.pready = 1'($urandom); apb.prdata = $urandom; apb.pslverr = 1'($urandom);
        end
        @(posedge sys_clk); #1;
      end
    end
    apb.pready = 1'b0;
    chk({name, ".rsp_seen"}, 64'(done), 64'(1));
    if (done) begin
      chk({name, ".latency"},   64'(lat),         64'(exp_lat));
      chk({name, ".psel_cyc"},  64'(sel_cnt),     64'(exp_sel));
      chk({name, ".psel_resp"}, 64'(apb.psel),    64'(0));
      chk({name, ".busy"},      64'(busy),        64'(1));
      for (int h = 0; h <= hold; h++) begin
        chk({name, ".rsp_valid"},   64'(rsp_valid),   64'(1));
        chk({name, ".rsp_rdata"},   64'(rsp_rdata),   64'(exp_rsp.rdata));
        chk({name, ".rsp_err"},     64'(rsp_err),     64'(exp_rsp.err));
        chk({name, ".rsp_timeout"}, 64'(rsp_timeout), 64'(exp_rsp.timeout));
        if (h < hold) begin
          @(posedge sys_clk); #1;
        end
      end
      rsp_ready = 1'b1;
      @(posedge sys_clk); #1;
      rsp_ready = 1'b0;
      chk({name, ".rsp_drop"},  64'(rsp_valid), 64'(0));
      chk({name, ".ready_ret"}, 64'(cmd_ready), 64'(1));
      chk({name, ".idle"},      64'(busy),      64'(0));
    end
  endtask

  logic [11:0] regs [8];
  logic [11:0] a;
  int          w, bound;

  initial begin
    regs[0] = TCR_ADDR;   regs[1] = TDR0_ADDR;  regs[2] = TDR1_ADDR;  regs[3] = TCMP0_ADDR;
    regs[4] = TCMP1_ADDR; regs[5] = TIER_ADDR;  regs[6] = TISR_ADDR;  regs[7] = THCSR_ADDR;
    sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst.cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst.psel",      64'(apb.psel),  64'(0));
    chk("rst.penable",   64'(apb.penable), 64'(0));
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst.busy",      64'(busy),      64'(0));
    chk("rst.rsp_err",   64'(rsp_err),   64'(0));
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    run_txn("wr_tcr",   1'b1, TCR_ADDR,  32'h0000_0101, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
    run_txn("rd_tdr0",  1'b0, TDR0_ADDR, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 1'b0, 3);
    run_txn("wr_div",   1'b1, TCR_ADDR,  32'h0000_0201, 4'hF, 1, 32'h0,         1'b1, 1);
    run_txn("rd_mis",   1'b0, 12'h006,   32'h0,         4'h0, 0, 32'hAAAA_5555, 1'b0, 2);
    run_txn("rd_err",   1'b0, TISR_ADDR, 32'h0,         4'h0, 2, 32'h5A5A_5A5A, 1'b1, 0);
`ifdef APB_TIMEOUT_EN
    run_txn("tmo_stuck", 1'b0, TDR1_ADDR, 32'h0, 4'h0, 50, 32'h0BAD_0BAD, 1'b0, 1);
    run_txn("tmo_last",  1'b0, TDR1_ADDR, 32'h0, 4'h0, int'(TMO) - 1, 32'h600D_F00D, 1'b0, 0);
`endif

    // Reset while in ACCESS: bus drops immediately, no response follows
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = TCMP0_ADDR; cmd_wdata = 32'h77; cmd_strb = 4'h3;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0; apb.pready = 1'b0;
    bound = 0;
    while (!(apb.psel && apb.penable) && bound < 8) begin
      @(posedge sys_clk); #1; bound++;
    end
    chk("rst_mid.in_access", 64'(apb.psel && apb.penable), 64'(1));
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_mid.psel",      64'(apb.psel),    64'(0));
    chk("rst_mid.penable",   64'(apb.penable), 64'(0));
    chk("rst_mid.rsp_valid", 64'(rsp_valid),   64'(0));
    chk("rst_mid.cmd_ready", 64'(cmd_ready),   64'(1));
    @(negedge sys_clk); sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      chk("rst_mid.no_rsp",   64'(rsp_valid), 64'(0));
      chk("rst_mid.ready",    64'(cmd_ready), 64'(1));
    end

    for (int t = 0; t < 40; t++) begin
      a = regs[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) a = a | 12'($urandom_range(1, 3));
`ifdef APB_TIMEOUT_EN
      w = $urandom_range(0, 6);
`else
      w = $urandom_range(0, 4);
`endif
      run_txn("rand", 1'($urandom), a, $urandom, 4'($urandom), w, $urandom,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
